nap_sequencer: RTL



---
 rtl/nap_sequencer.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nap_sequencer.sv
// ---------------------------------------------------------------------------
// nap_sequencer
//
// Main controller of the power-nap unit. It walks the nap through its
// phases (idle, auto or manual setting, sleep countdown, alarm, snooze and
// cancel) and owns the three phase timers. Those timers share a single
// down-counter, "remaining", which is decremented once per timer tick. A
// tick is produced by a prescaler that divides the clock by TICK_DIV, and
// the prescaler only runs while a timed phase (SLEEP, ALARM, SNOOZE) is
// active.
//
// Parameters
//   TIME_W        width of the tick counter, manual_time and remaining
//   TICK_DIV      clock cycles per timer tick (>= 2)
//   DEFAULT_NAP   nap length in ticks loaded in auto mode
//   ALARM_TIMEOUT ticks the alarm rings before it switches itself off
//   SNOOZE_TICKS  snooze length in ticks
//   MAX_SNOOZE    maximum snoozes allowed per nap
//   SNZ_W         width of snooze_cnt, derived from MAX_SNOOZE (minimum 1)
//
// Ports
//   reset              asynchronous, active-low reset
//   clock              system clock
//   mode               0 = auto setting, 1 = manual setting (sampled on go)
//   go                 start request, level-sampled in IDLE
//   set_done           setting complete strobe
//   manual_time        nap length in ticks, taken when set_done in MANUAL_SET
//   sharp              cancel key
//   snooze             snooze key
//   init               high in IDLE
//   en_auto_setting    high in AUTO_SET
//   en_manual_setting  high in MANUAL_SET
//   en_sleep           high in SLEEP
//   en_alarm           high in ALARM
//   en_snooze          high in SNOOZE
//   en_cancel          high in CANCEL
//   state_o            registered state encoding
//   remaining          ticks left in the current timed phase
//   snooze_cnt         snoozes used in the current nap
//   nap_done           one-cycle pulse in the first ALARM cycle after SLEEP
// ---------------------------------------------------------------------------
module nap_sequencer #(
    parameter int TIME_W        = 16,
    parameter int TICK_DIV      = 1000,
    parameter int DEFAULT_NAP   = 1200,
    parameter int ALARM_TIMEOUT = 600,
    parameter int SNOOZE_TICKS  = 300,
    parameter int MAX_SNOOZE    = 3,
    parameter int SNZ_W         = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1)
) (
    input  logic              reset,
    input  logic              clock,
    input  logic              mode,
    input  logic              go,
    input  logic              set_done,
    input  logic [TIME_W-1:0] manual_time,
    input  logic              sharp,
    input  logic              snooze,
    output logic              init,
    output logic              en_auto_setting,
    output logic              en_manual_setting,
    output logic              en_sleep,
    output logic              en_alarm,
    output logic              en_snooze,
    output logic              en_cancel,
    output logic [2:0]        state_o,
    output logic [TIME_W-1:0] remaining,
    output logic [SNZ_W-1:0]  snooze_cnt,
    output logic              nap_done
);

    // -----------------------------------------------------------------------
    // State encoding. These codes are visible on state_o and are shared with
    // the first-generation controller, so they must not be renumbered.
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_AUTO_SET   = 3'd0;
    localparam logic [2:0] S_SLEEP      = 3'd1;
    localparam logic [2:0] S_ALARM      = 3'd2;
    localparam logic [2:0] S_CANCEL     = 3'd3;
    localparam logic [2:0] S_IDLE       = 3'd4;
    localparam logic [2:0] S_MANUAL_SET = 3'd5;
    localparam logic [2:0] S_SNOOZE     = 3'd6;

    // -----------------------------------------------------------------------
    // Derived constants, pre-sized so every compare and load is width-exact.
    // -----------------------------------------------------------------------
    localparam int PRESC_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    localparam logic [PRESC_W-1:0] TICK_LAST   = PRESC_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]  NAP_LOAD    = TIME_W'(DEFAULT_NAP);
    localparam logic [TIME_W-1:0]  ALARM_LOAD  = TIME_W'(ALARM_TIMEOUT);
    localparam logic [TIME_W-1:0]  SNOOZE_LOAD = TIME_W'(SNOOZE_TICKS);
    localparam logic [TIME_W-1:0]  ONE_T       = TIME_W'(1);
    localparam logic [SNZ_W-1:0]   SNZ_MAX     = SNZ_W'(MAX_SNOOZE);
    localparam logic [SNZ_W-1:0]   ONE_S       = SNZ_W'(1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]         state_q,      state_d;
    logic [TIME_W-1:0]  remaining_q,  remaining_d;
    logic [SNZ_W-1:0]   snooze_cnt_q, snooze_cnt_d;
    logic [PRESC_W-1:0] presc_q,      presc_d;
    logic               nap_done_q,   nap_done_d;

    // -----------------------------------------------------------------------
    // Tick generation
    // -----------------------------------------------------------------------
    logic timed;
    logic tick;
    logic last_tick;
    logic may_snooze;

    assign timed = (state_q == S_SLEEP) ||
                   (state_q == S_ALARM) ||
                   (state_q == S_SNOOZE);

    // The prescaler is parked at 0 outside the timed states, so the first
    // tick of a phase arrives exactly TICK_DIV cycles after entry.
    assign tick       = timed && (presc_q == TICK_LAST);
    assign last_tick  = tick && (remaining_q == ONE_T);
    assign may_snooze = (snooze_cnt_q < SNZ_MAX);

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would make synthesis infer a latch.
        state_d      = state_q;
        remaining_d  = remaining_q;
        snooze_cnt_d = snooze_cnt_q;
        nap_done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = mode ? S_MANUAL_SET : S_AUTO_SET;
                end
            end

            S_AUTO_SET: begin
                if (sharp) begin
                    state_d = S_CANCEL;
                end else if (set_done) begin
                    state_d     = S_SLEEP;
                    remaining_d = NAP_LOAD;
                end
            end

            S_MANUAL_SET: begin
                // A zero-length manual nap is not a nap; set_done is ignored
                // until the user dials in something non-zero.
                if (sharp) begin
                    state_d = S_CANCEL;
                end else if (set_done && (manual_time != '0)) begin
                    state_d     = S_SLEEP;
                    remaining_d = manual_time;
                end
            end

            S_SLEEP: begin
                if (sharp) begin
                    state_d = S_CANCEL;
                end else if (last_tick) begin
                    state_d     = S_ALARM;
                    remaining_d = ALARM_LOAD;
                    nap_done_d  = 1'b1;
                end else if (tick && (remaining_q != '0)) begin
                    remaining_d = remaining_q - ONE_T;
                end
            end

            S_ALARM: begin
                // Snooze outranks the auto-off tick so a key press on the
                // final tick still buys another snooze if any are left.
                if (sharp) begin
                    state_d = S_CANCEL;
                end else if (snooze && may_snooze) begin
                    state_d      = S_SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + ONE_S;
                    remaining_d  = SNOOZE_LOAD;
                end else if (last_tick) begin
                    state_d = S_CANCEL;
                end else if (tick && (remaining_q != '0)) begin
                    remaining_d = remaining_q - ONE_T;
                end
            end

            S_SNOOZE: begin
                // Returning from snooze re-arms the alarm but is not the end
                // of the nap, so nap_done stays low here.
                if (sharp) begin
                    state_d = S_CANCEL;
                end else if (last_tick) begin
                    state_d     = S_ALARM;
                    remaining_d = ALARM_LOAD;
                end else if (tick && (remaining_q != '0)) begin
                    remaining_d = remaining_q - ONE_T;
                end
            end

            S_CANCEL: begin
                state_d      = S_IDLE;
                remaining_d  = '0;
                snooze_cnt_d = '0;
            end

            default: begin
                // Code 7 is unreachable in normal operation; recover to a
                // clean idle if an upset ever lands the register there.
                state_d      = S_IDLE;
                remaining_d  = '0;
                snooze_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Prescaler: free-runs 0..TICK_DIV-1 while a timed phase persists and
    // restarts from 0 on any state change, so each phase gets whole ticks.
    // -----------------------------------------------------------------------
    always_comb begin
        presc_d = '0;
        if (timed && (state_d == state_q) && (presc_q != TICK_LAST)) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // aborts a countdown immediately rather than at the next clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            snooze_cnt_q <= '0;
            presc_q      <= '0;
            nap_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop captures values
            // computed from the pre-edge state of all the others.
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            snooze_cnt_q <= snooze_cnt_d;
            presc_q      <= presc_d;
            nap_done_q   <= nap_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Moore outputs, decoded from the registered state only
    // -----------------------------------------------------------------------
    always_comb begin
        init              = 1'b0;
        en_auto_setting   = 1'b0;
        en_manual_setting = 1'b0;
        en_sleep          = 1'b0;
        en_alarm          = 1'b0;
        en_snooze         = 1'b0;
        en_cancel         = 1'b0;

        unique case (state_q)
            S_IDLE:       init              = 1'b1;
            S_AUTO_SET:   en_auto_setting   = 1'b1;
            S_MANUAL_SET: en_manual_setting = 1'b1;
            S_SLEEP:      en_sleep          = 1'b1;
            S_ALARM:      en_alarm          = 1'b1;
            S_SNOOZE:     en_snooze         = 1'b1;
            S_CANCEL:     en_cancel         = 1'b1;
            default:      init              = 1'b0;
        endcase
    end

    assign state_o    = state_q;
    assign remaining  = remaining_q;
    assign snooze_cnt = snooze_cnt_q;
    assign nap_done   = nap_done_q;

endmodule
